// File: rtl/cpu_pkg.sv
// Shared CPU definitions: loader state encoding and default bus widths,
// used by program_loader, memory and the fetch logic.
package cpu_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 8;
    localparam int DEFAULT_ADDRESS_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } loader_state_t;

    function automatic logic is_receiving(input loader_state_t s);
        return (s == ST_HEADER) || (s == ST_DATA) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/program_loader_byte_checksum.sv
// Modular byte-sum accumulator with synchronous clear and add enable.
// Instantiated by program_loader only when PROGRAM_LOADER_CHECKSUM_EN is defined.
module byte_checksum #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             add,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] sum
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Length-prefixed stream loader driving the memory write port from address 0.
// Optional trailing checksum byte: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import cpu_pkg::*;
#(
    parameter int CELL_COUNT    = 4,
    parameter int ADDRESS_WIDTH = cpu_pkg::DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = cpu_pkg::DEFAULT_DATA_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [ADDRESS_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0]    write_data,
    output logic                     write_enable,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam logic [DATA_WIDTH-1:0] MAX_LEN = DATA_WIDTH'(CELL_COUNT);
    localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);

    loader_state_t state;
    loader_state_t state_next;

    logic [DATA_WIDTH-1:0]    remaining;
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     xfer;
    logic                     len_ok;
    logic                     load_len;
    logic                     write_now;

    assign xfer   = in_valid & in_ready;
    assign len_ok = (in_data != '0) && (in_data <= MAX_LEN);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum;

    byte_checksum #(
        .WIDTH (DATA_WIDTH)
    ) u_checksum (
        .clock (clock),
        .reset (reset),
        .clear (load_len),
        .add   (write_now),
        .data  (in_data),
        .sum   (sum)
    );
`endif

    always_comb begin
        state_next = state;
        load_len   = 1'b0;
        write_now  = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) state_next = ST_HEADER;
            end
            ST_HEADER: begin
                if (xfer) begin
                    load_len   = len_ok;
                    state_next = len_ok ? ST_DATA : ST_ERROR;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    write_now = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    if (remaining == ONE) state_next = ST_CHECK;
`else
                    if (remaining == ONE) state_next = ST_DONE;
`endif
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (xfer) state_next = (in_data == sum) ? ST_DONE : ST_ERROR;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they
    // change in the same edge as the state itself.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= is_receiving(state_next);
            busy     <= is_receiving(state_next);
            done     <= (state_next == ST_DONE);
            error    <= (state_next == ST_ERROR);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
            address   <= '0;
        end else if (load_len) begin
            remaining <= in_data;
            address   <= '0;
        end else if (write_now) begin
            remaining <= remaining - ONE;
            address   <= address + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
        end else begin
            write_enable <= write_now;
            if (write_now) begin
                write_address <= address;
                write_data    <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized and directed bench for program_loader with a queue-based
// reference model of the expected write stream and memory contents.
module tb_program_loader;

    localparam int CELLS = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] write_address;
    logic [7:0] write_data;
    logic       write_enable;
    logic       busy;
    logic       done;
    logic       error;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int         wa[$];
    int         wd[$];
    int         wc[$];
    logic [7:0] mem_dut[CELLS];
    logic [7:0] mem_ref[CELLS];

    program_loader #(
        .CELL_COUNT    (CELLS),
        .ADDRESS_WIDTH (8),
        .DATA_WIDTH    (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .write_address (write_address),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Stand-in for the downstream memory: log every write pulse.
    always @(negedge clock) begin
        if (write_enable) begin
            wa.push_back(int'(write_address));
            wd.push_back(int'(write_data));
            wc.push_back(cyc);
            if (write_address < CELLS) mem_dut[write_address[1:0]] = write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int stall);
        bit   ok;
        logic rdy;
        ok = 1'b0;
        in_valid = 1'b0;
        repeat (stall) @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            rdy = in_ready;
            @(negedge clock);
            ok = rdy;
        end
        in_valid = 1'b0;
        check("accepted", 32'(ok), 32'd1);
    endtask

    // One complete load; the model says what must have been written.
    task automatic run_load(input string tag, input logic [7:0] len,
                            input logic [7:0] pl[$], input bit bad_ck,
                            input int stall, input bit b2b);
        bit         len_good;
        bit         exp_done;
        int         nexp;
        logic [7:0] s;
        len_good = (len >= 1) && (len <= CELLS);
        clear_log();
        pulse_start();
        check({tag, "_ready_after_start"}, 32'(in_ready), 32'd1);
        send(len, 0);
        s = 8'h00;
        if (len_good) begin
            for (int i = 0; i < int'(len); i++) begin
                send(pl[i], stall);
                s = s + pl[i];
                mem_ref[i] = pl[i];
            end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (len_good) send(bad_ck ? s ^ 8'h01 : s, stall);
        exp_done = len_good && !bad_ck;
`else
        exp_done = len_good;
`endif
        check({tag, "_status_edge"}, {30'd0, done, error}, {30'd0, exp_done, !exp_done});
        @(negedge clock);
        @(negedge clock);
        nexp = len_good ? int'(len) : 0;
        check({tag, "_nwrites"}, 32'(wa.size()), 32'(nexp));
        for (int i = 0; i < nexp && i < wa.size(); i++) begin
            check({tag, "_waddr"}, 32'(wa[i]), 32'(i));
            check({tag, "_wdata"}, 32'(wd[i]), 32'(pl[i]));
            if (b2b && i > 0) check({tag, "_consec"}, 32'(wc[i] - wc[i-1]), 32'd1);
        end
        check({tag, "_status"}, {29'd0, busy, done, error}, {29'd0, 1'b0, exp_done, !exp_done});
        check({tag, "_ready_low"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] len;
        int         bad_cnt;

        for (int i = 0; i < CELLS; i++) begin
            mem_dut[i] = 8'h00;
            mem_ref[i] = 8'h00;
        end

        // Reset held: every output low.
        repeat (3) @(negedge clock);
        check("reset_outputs",
              {11'd0, write_enable, write_address, write_data, in_ready, busy, done, error},
              32'd0);
        reset = 1'b1;
        bad_cnt = 0;
        repeat (20) begin
            @(negedge clock);
            if (in_ready || write_enable || busy || done || error) bad_cnt++;
        end
        check("idle_quiet", 32'(bad_cnt), 32'd0);

        // Nominal back-to-back load.
        pl = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_load("nominal", 8'h04, pl, 1'b0, 0, 1'b1);
        for (int i = 0; i < CELLS; i++) check("mem_nominal", 32'(mem_dut[i]), 32'(mem_ref[i]));

        // Bad lengths.
        pl = '{};
        run_load("len0", 8'h00, pl, 1'b0, 0, 1'b0);
        run_load("len5", 8'h05, pl, 1'b0, 0, 1'b0);

        // Stalls with a start pulse that must be ignored mid-load.
        clear_log();
        pulse_start();
        send(8'h02, 0);
        send(8'h10, 3);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("midstart_busy", 32'(busy), 32'd1);
        send(8'h20, 2);
        mem_ref[0] = 8'h10;
        mem_ref[1] = 8'h20;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send(8'h30, 3);
`endif
        @(negedge clock);
        check("stall_nwrites", 32'(wa.size()), 32'd2);
        check("stall_done", {30'd0, done, error}, 32'd2);
        if (wa.size() == 2) begin
            check("stall_w0", 32'((wa[0] << 8) | wd[0]), 32'h0010);
            check("stall_w1", 32'((wa[1] << 8) | wd[1]), 32'h0120);
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        pl = '{8'h80, 8'h90};
        run_load("ck_good", 8'h02, pl, 1'b0, 0, 1'b1);
        run_load("ck_bad", 8'h02, pl, 1'b1, 0, 1'b1);
        check("ck_bad_cell0", 32'(mem_dut[0]), 32'h80);
        check("ck_bad_cell1", 32'(mem_dut[1]), 32'h90);
`endif

        // Reset in the middle of a load.
        clear_log();
        pulse_start();
        send(8'h04, 0);
        send(8'h01, 0);
        send(8'h02, 0);
        mem_ref[0] = 8'h01;
        mem_ref[1] = 8'h02;
        reset = 1'b0;
        #1;
        check("midreset_outputs",
              {11'd0, write_enable, write_address, write_data, in_ready, busy, done, error},
              32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_ready", 32'(in_ready), 32'd0);
        pl = '{8'h55};
        run_load("after_reset", 8'h01, pl, 1'b0, 0, 1'b0);

        // Randomized loads, including illegal lengths and stalls.
        for (int n = 0; n < 25; n++) begin
            len = 8'($urandom_range(0, 6));
            pl = '{};
            for (int i = 0; i < int'(len); i++) pl.push_back(8'($urandom));
            run_load("rand", len, pl, bit'($urandom_range(0, 1)),
                     int'($urandom_range(0, 2)), 1'b0);
        end
        for (int i = 0; i < CELLS; i++) check("mem_final", 32'(mem_dut[i]), 32'(mem_ref[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
